freq_count_core: RTL

Datapath and gate-timer stage of the frequency meter. It sits directly downstream of the meter's sequencing FSM, which drives its clear / count-enable / lock strobes. It counts rising edges of an asynchronous test signal over a fixed gate of reference-clock cycles and returns a gate-done flag to the FSM, which ends the count phase. On lock, it captures the count into a held result register.

---
 rtl/freq_count_core_if.sv | 23 ++
 rtl/freq_count_core.sv | 98 +++++++++
 2 files changed

// File: rtl/freq_count_core_if.sv
// Strobe and result bundle between the meter's sequencing FSM (master)
// and the counting core (slave).
interface freq_count_core_if #(
    parameter int CNT_W = 32
);
    logic             clear_i;
    logic             count_en_i;
    logic             lock_i;
    logic             cout_o;
    logic [CNT_W-1:0] freq_o;
    logic             freq_valid_o;
    logic             ovf_o;

    modport master (
        output clear_i, count_en_i, lock_i,
        input  cout_o, freq_o, freq_valid_o, ovf_o
    );

    modport slave (
        input  clear_i, count_en_i, lock_i,
        output cout_o, freq_o, freq_valid_o, ovf_o
    );
endinterface

// File: rtl/freq_count_core.sv
// Frequency meter datapath: synchronises the measured signal, counts its
// rising edges over a window of GATE_CYCLES enabled reference cycles, flags
// gate completion to the sequencer and captures the result on lock.
module freq_count_core #(
    parameter int GATE_CYCLES = 50000000,
    parameter int GATE_W      = 26,
    parameter int CNT_W       = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sig_i,
    freq_count_core_if.slave   bus
);

    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  EDGE_MAX  = '1;

    logic              s1;
    logic              s2;
    logic              s3;
    logic              rise;
    logic              act;
    logic [GATE_W-1:0] gate_cnt;
    logic [CNT_W-1:0]  edge_cnt;
    logic              cout_q;
    logic              ovf_int;
    logic [CNT_W-1:0]  freq_q;
    logic              freq_valid_q;
    logic              ovf_q;

    assign rise = s2 & ~s3;
    assign act  = bus.count_en_i & ~cout_q;

    // Two-flop synchroniser plus edge register; only reset clears it so a
    // clear strobe cannot fabricate or swallow an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= sig_i;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // Gate timer and saturating edge counter; clear wins over counting and
    // the final enabled cycle still counts an edge while raising cout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gate_cnt <= '0;
            edge_cnt <= '0;
            cout_q   <= 1'b0;
            ovf_int  <= 1'b0;
        end else if (bus.clear_i) begin
            gate_cnt <= '0;
            edge_cnt <= '0;
            cout_q   <= 1'b0;
            ovf_int  <= 1'b0;
        end else if (act) begin
            if (gate_cnt == GATE_LAST) begin
                cout_q <= 1'b1;
            end else begin
                gate_cnt <= gate_cnt + 1'b1;
            end
            if (rise) begin
                if (edge_cnt == EDGE_MAX) begin
                    ovf_int <= 1'b1;
                end else begin
                    edge_cnt <= edge_cnt + 1'b1;
                end
            end
        end
    end

    // Result capture on every lock cycle, independent of gate state; values
    // are taken before any same-cycle clear lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            freq_q       <= '0;
            ovf_q        <= 1'b0;
            freq_valid_q <= 1'b0;
        end else begin
            freq_valid_q <= bus.lock_i;
            if (bus.lock_i) begin
                freq_q <= edge_cnt;
                ovf_q  <= ovf_int;
            end
        end
    end

    assign bus.cout_o       = cout_q;
    assign bus.freq_o       = freq_q;
    assign bus.freq_valid_o = freq_valid_q;
    assign bus.ovf_o        = ovf_q;

endmodule
